// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide controller for the EX stage.
// Radix-2 shift-add multiply / restoring divide over XLEN cycles, followed by a
// sign-correction step. Divide-by-zero and signed overflow resolve in IDLE.
// Optional build macro MULDIV_EARLY_OUT_EN: zero-operand multiplies and zero
// dividends skip the iteration (same result values, shorter latency).
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t            state;
  logic [2:0]        op;
  logic              sign_a;
  logic              sign_b;
  logic [CW-1:0]     count;
  logic [XLEN-1:0]   operand;   // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0] acc;       // product accumulator; multiplier shifts out of the low half
  logic [XLEN:0]     rem;       // partial remainder
  logic [XLEN-1:0]   quo;       // dividend shifts out, quotient bits shift in

  // Request decode: signedness, magnitudes and the cases resolved without iterating
  logic            a_signed;
  logic            b_signed;
  logic            sign_a_in;
  logic            sign_b_in;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            div_ovf;
  logic            early;
  logic            special;
  logic [XLEN-1:0] special_val;

  // Decode the incoming request from funct3 and the raw operands
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      3'b001:         begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:         a_signed = 1'b1;
      3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      default:        ;
    endcase
    sign_a_in = a_signed & rs1_val[XLEN-1];
    sign_b_in = b_signed & rs2_val[XLEN-1];
    mag_a     = sign_a_in ? (~rs1_val + 1'b1) : rs1_val;
    mag_b     = sign_b_in ? (~rs2_val + 1'b1) : rs2_val;
    div_zero  = funct3[2] && (rs2_val == '0);
    div_ovf   = funct3[2] && !funct3[0] && (rs1_val == MOST_NEG) && (rs2_val == '1);
`ifdef MULDIV_EARLY_OUT_EN
    if (funct3[2]) begin
      early = (rs1_val == '0) && (rs2_val != '0);
    end else begin
      early = (rs1_val == '0) || (rs2_val == '0);
    end
`else
    early = 1'b0;
`endif
    special     = div_zero | div_ovf | early;
    special_val = '0;
    if (div_zero) begin
      special_val = funct3[1] ? rs1_val : '1;
    end else if (div_ovf) begin
      special_val = funct3[1] ? '0 : rs1_val;
    end
  end

  // Iteration datapath and final sign correction / result selection
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_diff;
  logic              div_fits;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_val;

  // One shift-add / shift-subtract step plus the FIX-stage result mux
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    // rem never exceeds the divisor, so the top bit of the difference is a clean borrow
    div_diff = {rem, quo[XLEN-1]} - {2'b00, operand};
    div_fits = ~div_diff[XLEN+1];
    prod_fix = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
    quo_fix  = (sign_a ^ sign_b) ? (~quo + 1'b1) : quo;
    rem_fix  = sign_a ? (~rem[XLEN-1:0] + 1'b1) : rem[XLEN-1:0];
    case (op)
      3'b000:                 fix_val = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_val = quo_fix;
      default:                fix_val = rem_fix;
    endcase
  end

  // Control FSM with registered busy/done/result and operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      op      <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      count   <= '0;
      operand <= '0;
      acc     <= '0;
      rem     <= '0;
      quo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op     <= funct3;
            sign_a <= sign_a_in;
            sign_b <= sign_b_in;
            count  <= CNT_INIT;
            rem    <= '0;
            if (funct3[2]) begin
              operand <= mag_b;
              quo     <= mag_a;
              acc     <= '0;
            end else begin
              operand <= mag_a;
              acc     <= {{XLEN{1'b0}}, mag_b};
              quo     <= '0;
            end
            if (special) begin
              result <= special_val;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            count <= count - 1'b1;
            if (op[2]) begin
              rem <= div_fits ? div_diff[XLEN:0] : {1'b0, rem[XLEN-1:0], quo[XLEN-1]};
              quo <= {quo[XLEN-2:0], div_fits};
            end else begin
              acc <= {mul_sum, acc[XLEN-1:1]};
            end
            if (count == CNT_LAST) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            result <= fix_val;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors with a scoreboard queue; a monitor
// pops and checks result, latency and busy whenever done is seen.
module tb_muldiv_sequencer;

  localparam int XLEN = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 34;
`endif

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .flush   (flush),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  typedef struct {
    logic [31:0] value;
    int          lat;
    int          start_cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_exp = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with result 0x%08h expected no done", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, result, e.value);
        check({e.name, "_latency"}, 32'(cyc - e.start_cyc + 1), 32'(e.lat));
        check({e.name, "_busy_in_done"}, {31'b0, busy}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string name);
    exp_t e;
    @(negedge clk);
    start   = 1'b1;
    funct3  = f;
    rs1_val = a;
    rs2_val = b;
    e.value = exp;
    e.lat = lat;
    e.start_cyc = cyc + 1;
    e.name = name;
    sb.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    funct3  = 3'($urandom);
    rs1_val = $urandom;
    rs2_val = $urandom;
    check({name, "_busy_after_start"}, {31'b0, busy}, (lat > 1) ? 32'd1 : 32'd0);
    last_exp = exp;
  endtask

  task automatic raw_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start   = 1'b1;
    funct3  = f;
    rs1_val = a;
    rs2_val = b;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d outstanding results expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat, input string name);
    issue(f, a, b, exp, lat, name);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    flush   = 1'b0;
    funct3  = '0;
    rs1_val = '0;
    rs2_val = '0;
    #12;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(3'b000, 32'd7,        32'd6,        32'd42,       34, "mul_7x6");
    run(3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 34, "mul_neg3x5");
    run(3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34, "mulh");
    run(3'b011, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 34, "mulhu");
    run(3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34, "mulhsu");
    run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu_max");
    run(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34, "mul_max");
    run(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "div_neg7_2");
    run(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "rem_neg7_2");
    run(3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, "div_7_neg2");
    run(3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 34, "rem_7_neg2");
    run(3'b101, 32'd100,      32'd7,        32'd14,       34, "divu_100_7");
    run(3'b111, 32'd100,      32'd7,        32'd2,        34, "remu_100_7");
    run(3'b100, 32'd123,      32'd0,        32'hFFFFFFFF, 1,  "div_by_zero");
    run(3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, 1,  "divu_by_zero");
    run(3'b111, 32'd5,        32'd0,        32'd5,        1,  "remu_by_zero");
    run(3'b110, 32'hFFFFFFFD, 32'd0,        32'hFFFFFFFD, 1,  "rem_by_zero");
    run(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_overflow");
    run(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "rem_overflow");
    run(3'b100, 32'h80000000, 32'd2,        32'hC0000000, 34, "div_mostneg_2");

    // Start pulses while busy must be ignored
    issue(3'b000, 32'd11, 32'd13, 32'd143, 34, "mul_busy_starts");
    for (int p = 0; p < 3; p++) begin
      repeat (6) @(negedge clk);
      start   = 1'b1;
      funct3  = 3'b100;
      rs1_val = 32'd1;
      rs2_val = 32'd0;
      @(negedge clk);
      start   = 1'b0;
    end
    wait_idle();

    // Flush mid-CALC: back to IDLE, no done, result held
    raw_start(3'b000, 32'd3, 32'd5);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_result_held", result, last_exp);
    repeat (40) @(negedge clk);
    check("flush_result_still_held", result, last_exp);
    run(3'b000, 32'd3, 32'd5, 32'd15, 34, "mul_after_flush");

    // Asynchronous reset mid-CALC
    raw_start(3'b000, 32'd9, 32'd9);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", {31'b0, busy}, 32'd0);
    check("async_reset_done", {31'b0, done}, 32'd0);
    check("async_reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_exp = '0;

    run(3'b000, 32'd0,  32'd9, 32'd0, ZLAT, "mul_zero");
    run(3'b011, 32'd17, 32'd0, 32'd0, ZLAT, "mulhu_zero");
    run(3'b100, 32'd0,  32'd5, 32'd0, ZLAT, "div_zero_dividend");
    run(3'b111, 32'd0,  32'd5, 32'd0, ZLAT, "remu_zero_dividend");

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide controller for the EX stage of the pipelined core.
- Accepts one M-extension operation at a time, selected by funct3.
- Runs a radix-2 shift-add multiply or restoring divide over XLEN cycles, then applies the sign correction.
- Returns one result together with a single-cycle done pulse. The hazard logic keeps the pipeline stalled while `start` is high and `done` is low.

Parameters:
- XLEN, 32, operand and result width. Iteration count equals XLEN.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled only in IDLE.
- flush  input  1  kill the in-flight operation (branch mispredict or trap).
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_val  input  XLEN  operand A (multiplicand or dividend).
- rs2_val  input  XLEN  operand B (multiplier or divisor).
- busy  output  1  registered; high in CALC and FIX.
- done  output  1  registered; one-cycle pulse when result is valid.
- result  output  XLEN  registered; held until the next done.

Behaviour:
- **Reset:** clk is the only clock. On rst_n=0, asynchronously: state=IDLE, busy=0, done=0, result=0, and all internal accumulator, counter and sign registers are 0.
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE:**
  - If start=1 and flush=0: latch funct3, operand magnitudes and result sign; load counter=XLEN.
  - The next state is CALC, or DONE if the operation is a special case.
  - start while not in IDLE is ignored.
- **Signedness:**
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV, REM: signed.
  - Negative signed operands are converted to magnitude on capture.
- **CALC:**
  - One iteration per cycle; counter decrements; when counter reaches 1, go to FIX.
  - Multiply uses a 2*XLEN accumulator.
  - Divide uses an XLEN-bit quotient and an XLEN+1-bit partial remainder.
- **FIX:**
  - Negate the product if sign(A) xor sign(B) under the operand signedness above.
  - Quotient negated if the signs differ; remainder takes the sign of the dividend.
  - Selection: MUL takes the low XLEN bits; MULH, MULHSU and MULHU take the high XLEN bits; DIV and DIVU take the quotient; REM and REMU take the remainder.
  - Write result, go to DONE.
- **DONE:** done=1 for exactly this cycle; next state is IDLE. busy=0 in DONE.
- **Latency:**
  - Normal operation: done asserted XLEN+2 edges after the edge that sampled start (34 for XLEN=32).
  - Special cases: done asserted 1 edge after start.
- **Special cases** (resolved in IDLE, no CALC):
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = rs1_val.
  - Signed overflow (rs1 = most-negative value, rs2 = -1): DIV result = rs1_val; REM result = 0.
- **Back-to-back:**
  - The cycle after DONE is IDLE, so a start held high is accepted there.
  - The pipeline must drop start in the cycle done is seen, otherwise the operation re-executes.
- **Flush:**
  - In any non-IDLE state, flush=1 forces IDLE at the next edge.
  - No done is produced and result is unchanged.
  - flush and start together in IDLE: flush wins and nothing is accepted.
  - flush in DONE: the done pulse still appears (it is already registered), then IDLE.
- **Operand stability:** rs1_val and rs2_val are not required to be stable after the start edge; all operands are captured internally.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- **Defined:**
  - Multiply with either captured operand equal to 0 goes directly to DONE with result=0, 1-edge latency.
  - Divide with rs1_val=0 and a nonzero divisor goes to DONE with result=0, 1-edge latency.
- **Undefined:**
  - These cases take the full XLEN+2 latency and produce the same result values.
  - Bit-exact results are required in both builds; only latency differs.

Test Plan:
- **MUL:** reset, then start MUL rs1=7, rs2=6 → busy next cycle; done exactly 34 edges after start; result=42; busy=0 during done.
- **High-half multiplies** (rs1=0xFFFFFFFF, rs2=0x00000002):
  - MULH → 0xFFFFFFFF.
  - MULHU → 0x00000001.
  - MULHSU → 0xFFFFFFFF.
- **Signed divide:** DIV rs1=-7, rs2=2 → 0xFFFFFFFD (-3); REM same operands → 0xFFFFFFFF (-1); DIVU 100/7 → 14; REMU → 2.
- **Special cases:**
  - DIV x/0 → done after 1 edge, result 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- **Flush and start-while-busy:**
  - Start MUL 3*5, assert flush at CALC cycle 10 → IDLE next edge, no done pulse, result keeps its prior value.
  - Immediately start MUL 3*5 again → 15.
  - Start pulses while busy are ignored.
- **Reset and early-out:**
  - Assert rst_n=0 mid-CALC (asynchronous, between edges) → busy, done and result read 0 immediately.
  - After release, MUL 0*9 with MULDIV_EARLY_OUT_EN → done after 1 edge, result 0; without the macro → 34 edges, result 0.
